// File: rtl/input_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | input_pkg : keycodes, FSM states and step decode for player input  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package input_pkg;

   localparam logic [15:0] KEY_W   = 16'h001A;
   localparam logic [15:0] KEY_A   = 16'h0004;
   localparam logic [15:0] KEY_S   = 16'h0016;
   localparam logic [15:0] KEY_D   = 16'h0007;
   localparam logic [15:0] KEY_ESC = 16'h0029;
   localparam logic [15:0] KEY_WA  = 16'h1A04;
   localparam logic [15:0] KEY_AS  = 16'h0416;
   localparam logic [15:0] KEY_SD  = 16'h1607;
   localparam logic [15:0] KEY_DW  = 16'h071A;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      WAIT = 2'd1,
      MENU = 2'd2
   } state_t;

   // Both fields are 4-bit two's complement; negative dy is up.
   typedef struct packed {
      logic [3:0] dx;
      logic [3:0] dy;
   } dir_t;

   function automatic dir_t decode_key(input logic [15:0] key, input logic [3:0] step);
      dir_t       d;
      logic [3:0] neg;
      neg  = 4'd0 - step;
      d.dx = 4'd0;
      d.dy = 4'd0;
      case (key)
         KEY_WA:  begin d.dx = neg;  d.dy = neg;  end
         KEY_AS:  begin d.dx = neg;  d.dy = step; end
         KEY_SD:  begin d.dx = step; d.dy = step; end
         KEY_DW:  begin d.dx = step; d.dy = neg;  end
         KEY_A:   d.dx = neg;
         KEY_D:   d.dx = step;
         KEY_S:   d.dy = step;
         KEY_W:   d.dy = neg;
         default: ;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_input_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | player_input_ctrl_if : frame/key inputs and move/menu outputs      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface player_input_ctrl_if;
   logic        frame_tick;
   logic [15:0] keycode;
   logic        game_active;
   logic        move_ready;
   logic        move_valid;
   logic [3:0]  move_dx;
   logic [3:0]  move_dy;
   logic        menu_open;
   logic        menu_toggle;
   logic        overrun;

   modport master (
      input  frame_tick, keycode, game_active, move_ready,
      output move_valid, move_dx, move_dy, menu_open, menu_toggle, overrun
   );

   modport slave (
      output frame_tick, keycode, game_active, move_ready,
      input  move_valid, move_dx, move_dy, menu_open, menu_toggle, overrun
   );
endinterface
`default_nettype wire

// File: rtl/esc_arm_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esc_arm_counter : counts ESC-free frames, armed once saturated     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module esc_arm_counter #(
   parameter int ESC_RELEASE_FRAMES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic esc_seen,
   output logic armed
);

   localparam logic [3:0] ARM_MAX = 4'(ESC_RELEASE_FRAMES);

   logic [3:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 4'd0;
      end else if (tick) begin
         if (esc_seen)
            count <= 4'd0;
         else if (count != ARM_MAX)
            count <= count + 4'd1;
      end
   end

   // Reflects the count before this tick's update, so an ESC tick sees
   // whether the preceding frames were ESC-free.
   assign armed = (count == ARM_MAX);

endmodule
`default_nettype wire

// File: rtl/player_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | player_input_ctrl : per-frame keycode to move requests and menu    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module player_input_ctrl
   import input_pkg::*;
#(
   parameter int STEP               = 1,
   parameter int ESC_RELEASE_FRAMES = 3
) (
   input  logic               clk,
   input  logic               rst,
   player_input_ctrl_if.master bus
);

   localparam logic [3:0] STEP_W = 4'(STEP);

   state_t     state, state_n;
   logic       valid_q, valid_n;
   logic [3:0] dx_q, dx_n;
   logic [3:0] dy_q, dy_n;
   logic       menu_q, menu_n;
   logic       toggle_q, toggle_n;
   logic       overrun_q, overrun_n;

   logic       esc_seen;
   logic       armed;
   logic       dir_valid;
   dir_t       dir;

   assign esc_seen  = (bus.keycode == KEY_ESC);
   assign dir       = decode_key(bus.keycode, STEP_W);
   assign dir_valid = (dir.dx != 4'd0) || (dir.dy != 4'd0);

   esc_arm_counter #(
      .ESC_RELEASE_FRAMES(ESC_RELEASE_FRAMES)
   ) u_esc_arm (
      .clk      (clk),
      .rst      (rst),
      .tick     (bus.frame_tick),
      .esc_seen (esc_seen),
      .armed    (armed)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PLAY;
         valid_q   <= 1'b0;
         dx_q      <= 4'd0;
         dy_q      <= 4'd0;
         menu_q    <= 1'b0;
         toggle_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_n;
         valid_q   <= valid_n;
         dx_q      <= dx_n;
         dy_q      <= dy_n;
         menu_q    <= menu_n;
         toggle_q  <= toggle_n;
         overrun_q <= overrun_n;
      end
   end

   always_comb begin
      state_n   = state;
      valid_n   = valid_q;
      dx_n      = dx_q;
      dy_n      = dy_q;
      menu_n    = menu_q;
      toggle_n  = 1'b0;
      overrun_n = overrun_q;
      case (state)
         PLAY: begin
            if (bus.frame_tick) begin
               if (esc_seen && armed) begin
                  toggle_n = 1'b1;
                  menu_n   = 1'b1;
                  state_n  = MENU;
               end else if (dir_valid && bus.game_active) begin
                  dx_n    = dir.dx;
                  dy_n    = dir.dy;
                  valid_n = 1'b1;
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            // The pending move owns this frame; its tick is dropped.
            if (bus.frame_tick)
               overrun_n = 1'b1;
            if (bus.move_ready) begin
               valid_n = 1'b0;
               state_n = PLAY;
            end
         end
         MENU: begin
            if (bus.frame_tick && esc_seen && armed) begin
               toggle_n = 1'b1;
               menu_n   = 1'b0;
               state_n  = PLAY;
            end
         end
         default: state_n = PLAY;
      endcase
   end

   assign bus.move_valid  = valid_q;
   assign bus.move_dx     = dx_q;
   assign bus.move_dy     = dy_q;
   assign bus.menu_open   = menu_q;
   assign bus.menu_toggle = toggle_q;
   assign bus.overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_player_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_player_input_ctrl : directed bench, STEP=1 and STEP=3 instances |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_player_input_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic [15:0] keycode = 16'h0000;
   logic        game_active = 1'b0;
   logic        move_ready = 1'b0;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   player_input_ctrl_if ifa ();
   player_input_ctrl_if ifb ();

   assign ifa.frame_tick  = frame_tick;
   assign ifa.keycode     = keycode;
   assign ifa.game_active = game_active;
   assign ifa.move_ready  = move_ready;
   assign ifb.frame_tick  = frame_tick;
   assign ifb.keycode     = keycode;
   assign ifb.game_active = game_active;
   assign ifb.move_ready  = move_ready;

   player_input_ctrl dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.master)
   );

   player_input_ctrl #(.STEP(3), .ESC_RELEASE_FRAMES(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.master)
   );

   // One-cycle frame pulse; returns 1 time unit after the sampling edge.
   task automatic pulse(input logic [15:0] key);
      @(negedge clk);
      keycode    = key;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ifa.move_valid); end
      checks++; if (ifa.move_dx !== 4'h0) begin fails++; $display("FAIL reset_dx: got %h want 0", ifa.move_dx); end
      checks++; if (ifa.move_dy !== 4'h0) begin fails++; $display("FAIL reset_dy: got %h want 0", ifa.move_dy); end
      checks++; if (ifa.menu_open !== 1'b0) begin fails++; $display("FAIL reset_menu: got %b want 0", ifa.menu_open); end
      checks++; if (ifa.menu_toggle !== 1'b0) begin fails++; $display("FAIL reset_toggle: got %b want 0", ifa.menu_toggle); end
      checks++; if (ifa.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", ifa.overrun); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_menu_open;
      game_active = 1'b1;
      move_ready  = 1'b1;
      repeat (3) pulse(16'h0000);
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL none_no_move: got %b want 0", ifa.move_valid); end
      pulse(16'h0029);
      checks++; if (ifa.menu_toggle !== 1'b1) begin fails++; $display("FAIL open_toggle: got %b want 1", ifa.menu_toggle); end
      checks++; if (ifa.menu_open !== 1'b1) begin fails++; $display("FAIL open_menu: got %b want 1", ifa.menu_open); end
      checks++; if (ifb.menu_toggle !== 1'b1) begin fails++; $display("FAIL open_toggle_b: got %b want 1", ifb.menu_toggle); end
      @(posedge clk); #1;
      checks++; if (ifa.menu_toggle !== 1'b0) begin fails++; $display("FAIL toggle_width: got %b want 0", ifa.menu_toggle); end
      checks++; if (ifa.menu_open !== 1'b1) begin fails++; $display("FAIL open_hold: got %b want 1", ifa.menu_open); end
      for (int i = 0; i < 5; i++) begin
         pulse(16'h0029);
         checks++; if (ifa.menu_toggle !== 1'b0) begin fails++; $display("FAIL esc_held_%0d: toggle got %b want 0", i, ifa.menu_toggle); end
      end
      checks++; if (ifa.menu_open !== 1'b1) begin fails++; $display("FAIL esc_held_menu: got %b want 1", ifa.menu_open); end
   endtask

   task automatic test_menu_close;
      for (int i = 0; i < 3; i++) begin
         pulse(16'h001A);
         checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL menu_dir_%0d: valid got %b want 0", i, ifa.move_valid); end
      end
      pulse(16'h0029);
      checks++; if (ifa.menu_toggle !== 1'b1) begin fails++; $display("FAIL close_toggle: got %b want 1", ifa.menu_toggle); end
      checks++; if (ifa.menu_open !== 1'b0) begin fails++; $display("FAIL close_menu: got %b want 0", ifa.menu_open); end
      @(posedge clk); #1;
      checks++; if (ifa.menu_toggle !== 1'b0) begin fails++; $display("FAIL close_width: got %b want 0", ifa.menu_toggle); end
   endtask

   task automatic test_diagonal;
      move_ready = 1'b1;
      pulse(16'h1A04);
      checks++; if (ifa.move_valid !== 1'b1) begin fails++; $display("FAIL diag_valid: got %b want 1", ifa.move_valid); end
      checks++; if ({ifa.move_dx, ifa.move_dy} !== 8'hFF) begin fails++; $display("FAIL diag_dxdy: got %h want ff", {ifa.move_dx, ifa.move_dy}); end
      checks++; if ({ifb.move_dx, ifb.move_dy} !== 8'hDD) begin fails++; $display("FAIL diag_dxdy_b: got %h want dd", {ifb.move_dx, ifb.move_dy}); end
      @(posedge clk); #1;
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL diag_accept: got %b want 0", ifa.move_valid); end
   endtask

   task automatic test_overrun_hold;
      move_ready = 1'b0;
      pulse(16'h0016);
      checks++; if (ifb.move_valid !== 1'b1) begin fails++; $display("FAIL hold_valid: got %b want 1", ifb.move_valid); end
      checks++; if ({ifb.move_dx, ifb.move_dy} !== 8'h03) begin fails++; $display("FAIL hold_dxdy_b: got %h want 03", {ifb.move_dx, ifb.move_dy}); end
      checks++; if ({ifa.move_dx, ifa.move_dy} !== 8'h01) begin fails++; $display("FAIL hold_dxdy_a: got %h want 01", {ifa.move_dx, ifa.move_dy}); end
      checks++; if (ifb.overrun !== 1'b0) begin fails++; $display("FAIL hold_no_overrun: got %b want 0", ifb.overrun); end
      @(negedge clk);
      keycode = 16'h1607;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({ifb.move_dx, ifb.move_dy} !== 8'h03) begin fails++; $display("FAIL midframe_dxdy: got %h want 03", {ifb.move_dx, ifb.move_dy}); end
      for (int i = 0; i < 2; i++) begin
         pulse(16'h1607);
         checks++; if (ifb.overrun !== 1'b1) begin fails++; $display("FAIL overrun_%0d: got %b want 1", i, ifb.overrun); end
         checks++; if (ifb.move_valid !== 1'b1) begin fails++; $display("FAIL wait_valid_%0d: got %b want 1", i, ifb.move_valid); end
         checks++; if ({ifb.move_dx, ifb.move_dy} !== 8'h03) begin fails++; $display("FAIL wait_dxdy_%0d: got %h want 03", i, {ifb.move_dx, ifb.move_dy}); end
      end
      @(negedge clk);
      move_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (ifb.move_valid !== 1'b0) begin fails++; $display("FAIL late_accept: got %b want 0", ifb.move_valid); end
      checks++; if (ifb.overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b want 1", ifb.overrun); end
   endtask

   task automatic test_game_inactive;
      @(negedge clk);
      game_active = 1'b0;
      move_ready  = 1'b1;
      pulse(16'h0007);
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL inactive_tick: got %b want 0", ifa.move_valid); end
      @(posedge clk); #1;
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL inactive_after: got %b want 0", ifa.move_valid); end
      @(negedge clk);
      game_active = 1'b1;
      pulse(16'h0007);
      checks++; if (ifa.move_valid !== 1'b1) begin fails++; $display("FAIL active_valid: got %b want 1", ifa.move_valid); end
      checks++; if ({ifa.move_dx, ifa.move_dy} !== 8'h10) begin fails++; $display("FAIL active_dxdy: got %h want 10", {ifa.move_dx, ifa.move_dy}); end
      checks++; if ({ifb.move_dx, ifb.move_dy} !== 8'h30) begin fails++; $display("FAIL active_dxdy_b: got %h want 30", {ifb.move_dx, ifb.move_dy}); end
      @(posedge clk); #1;
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL active_accept: got %b want 0", ifa.move_valid); end
   endtask

   task automatic test_reset_mid_wait;
      move_ready = 1'b0;
      pulse(16'h0004);
      checks++; if (ifa.move_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b want 1", ifa.move_valid); end
      checks++; if (ifa.move_dx !== 4'hF) begin fails++; $display("FAIL pre_reset_dx: got %h want f", ifa.move_dx); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (ifa.move_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b want 0", ifa.move_valid); end
      checks++; if (ifb.move_valid !== 1'b0) begin fails++; $display("FAIL async_valid_b: got %b want 0", ifb.move_valid); end
      @(posedge clk); #1;
      checks++; if ({ifb.move_dx, ifb.move_dy} !== 8'h00) begin fails++; $display("FAIL rst_dxdy: got %h want 00", {ifb.move_dx, ifb.move_dy}); end
      checks++; if (ifb.overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b want 0", ifb.overrun); end
      checks++; if ({ifa.menu_open, ifa.menu_toggle} !== 2'b00) begin fails++; $display("FAIL rst_menu: got %b want 00", {ifa.menu_open, ifa.menu_toggle}); end
      @(negedge clk);
      rst = 1'b0;
      pulse(16'h0029);
      checks++; if (ifa.menu_toggle !== 1'b0) begin fails++; $display("FAIL esc_disarmed: got %b want 0", ifa.menu_toggle); end
      checks++; if (ifa.menu_open !== 1'b0) begin fails++; $display("FAIL esc_disarmed_menu: got %b want 0", ifa.menu_open); end
   endtask

   initial begin
      test_reset();
      test_menu_open();
      test_menu_close();
      test_diagonal();
      test_overrun_hold();
      test_game_inactive();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
